// File: rtl/simple_alu_pipe_if.sv
// Operand, result and CSR buses of simple_alu_pipe, grouped for one connection.
// The ALU is the slave; the block that feeds operands and drives the CSRs is the master.
interface simple_alu_pipe_if #(
  parameter int SpatPar      = 4,
  parameter int DataWidth    = 64,
  parameter int RegDataWidth = 32,
  parameter int RegAddrWidth = 3
);
  logic [SpatPar*DataWidth-1:0] a_i;
  logic [SpatPar*DataWidth-1:0] b_i;
  logic                         a_valid_i;
  logic                         b_valid_i;
  logic                         a_ready_o;
  logic                         b_ready_o;
  logic [SpatPar*DataWidth-1:0] result_o;
  logic                         result_valid_o;
  logic                         result_ready_i;

  logic [RegAddrWidth-1:0]      csr_addr_i;
  logic [RegDataWidth-1:0]      csr_wr_data_i;
  logic                         csr_wr_en_i;
  logic                         csr_req_valid_i;
  logic                         csr_req_ready_o;
  logic [RegDataWidth-1:0]      csr_rd_data_o;
  logic                         csr_rsp_valid_o;
  logic                         csr_rsp_ready_i;

  modport slave (
    input  a_i, b_i, a_valid_i, b_valid_i, result_ready_i,
           csr_addr_i, csr_wr_data_i, csr_wr_en_i, csr_req_valid_i, csr_rsp_ready_i,
    output a_ready_o, b_ready_o, result_o, result_valid_o,
           csr_req_ready_o, csr_rd_data_o, csr_rsp_valid_o
  );

  modport master (
    output a_i, b_i, a_valid_i, b_valid_i, result_ready_i,
           csr_addr_i, csr_wr_data_i, csr_wr_en_i, csr_req_valid_i, csr_rsp_ready_i,
    input  a_ready_o, b_ready_o, result_o, result_valid_o,
           csr_req_ready_o, csr_rd_data_o, csr_rsp_valid_o
  );
endinterface

// File: rtl/simple_alu_pipe.sv
// SpatPar-lane ALU with a PipeDepth-stage stall-as-a-whole pipeline and a small CSR bank.
// The result is computed as a beat enters; later stages only delay it, so MODE/SAT_EN travel implicitly.
module simple_alu_pipe #(
  parameter int SpatPar      = 4,
  parameter int DataWidth    = 64,
  parameter int PipeDepth    = 2,
  parameter int RegCount     = 8,
  parameter int RegDataWidth = 32,
  parameter int RegAddrWidth = $clog2(RegCount)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  simple_alu_pipe_if.slave     bus,
  output logic                 busy_o
);

  localparam int BusWidth = SpatPar * DataWidth;

  typedef enum logic [2:0] {
    ModeAdd, ModeSub, ModeMul, ModeXor, ModeAnd, ModeOr, ModeMax, ModeMin
  } mode_e;

  function automatic logic [DataWidth-1:0] alu_lane(
    input logic [DataWidth-1:0] a,
    input logic [DataWidth-1:0] b,
    input mode_e                mode,
    input logic                 sat
  );
    logic [DataWidth-1:0] sum, diff, pos_lim, neg_lim, res;
    logic                 ovf_add, ovf_sub;
    pos_lim = {1'b0, {(DataWidth-1){1'b1}}};
    neg_lim = {1'b1, {(DataWidth-1){1'b0}}};
    sum     = a + b;
    diff    = a - b;
    // Signed overflow always saturates toward the sign of operand a.
    ovf_add = (a[DataWidth-1] == b[DataWidth-1]) && (sum[DataWidth-1]  != a[DataWidth-1]);
    ovf_sub = (a[DataWidth-1] != b[DataWidth-1]) && (diff[DataWidth-1] != a[DataWidth-1]);
    case (mode)
      ModeAdd: res = (sat && ovf_add) ? (a[DataWidth-1] ? neg_lim : pos_lim) : sum;
      ModeSub: res = (sat && ovf_sub) ? (a[DataWidth-1] ? neg_lim : pos_lim) : diff;
      ModeMul: res = a * b;
      ModeXor: res = a ^ b;
      ModeAnd: res = a & b;
      ModeOr:  res = a | b;
      ModeMax: res = ($signed(a) > $signed(b)) ? a : b;
      default: res = ($signed(a) < $signed(b)) ? a : b;
    endcase
    return res;
  endfunction

  logic [PipeDepth-1:0]    valid_q, valid_d;
  logic [BusWidth-1:0]     data_q [PipeDepth];
  logic [BusWidth-1:0]     data_d [PipeDepth];
  logic [BusWidth-1:0]     alu_res;
  logic                    in_ready, in_fire, out_fire;

  mode_e                   mode_q, mode_d;
  logic                    sat_q, sat_d;
  logic [31:0]             count_q, count_d;
  logic [RegDataWidth-1:0] rd_data_q, rd_data_d;
  logic                    rsp_valid_q, rsp_valid_d;
  logic                    addr_mode, addr_sat, addr_count, addr_clear;
  logic                    cfg_write, csr_fire, clear_hit;

  assign in_ready           = !valid_q[PipeDepth-1] || bus.result_ready_i;
  assign in_fire            = !rst_i && in_ready && bus.a_valid_i && bus.b_valid_i;
  assign out_fire           = valid_q[PipeDepth-1] && bus.result_ready_i;
  assign bus.a_ready_o      = !rst_i && in_ready && bus.b_valid_i;
  assign bus.b_ready_o      = !rst_i && in_ready && bus.a_valid_i;
  assign bus.result_valid_o = valid_q[PipeDepth-1];
  assign bus.result_o       = data_q[PipeDepth-1];
  assign busy_o             = |valid_q;

  assign addr_mode  = bus.csr_addr_i == RegAddrWidth'(0);
  assign addr_sat   = bus.csr_addr_i == RegAddrWidth'(1);
  assign addr_count = bus.csr_addr_i == RegAddrWidth'(2);
  assign addr_clear = bus.csr_addr_i == RegAddrWidth'(3);
  // Only configuration writes wait for an empty pipeline; reads and CLEAR go straight through.
  assign cfg_write  = bus.csr_wr_en_i && (addr_mode || addr_sat);
  assign bus.csr_req_ready_o = !rst_i && !rsp_valid_q && !(cfg_write && busy_o);
  assign csr_fire   = bus.csr_req_valid_i && bus.csr_req_ready_o;
  assign clear_hit  = csr_fire && bus.csr_wr_en_i && addr_clear && bus.csr_wr_data_i[0];
  assign bus.csr_rd_data_o   = rd_data_q;
  assign bus.csr_rsp_valid_o = rsp_valid_q;

  always_comb begin
    alu_res = '0;
    for (int l = 0; l < SpatPar; l++) begin
      alu_res[l*DataWidth +: DataWidth] = alu_lane(bus.a_i[l*DataWidth +: DataWidth],
                                                   bus.b_i[l*DataWidth +: DataWidth],
                                                   mode_q, sat_q);
    end
  end

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (in_ready) begin
      valid_d[0] = in_fire;
      data_d[0]  = alu_res;
      for (int s = 1; s < PipeDepth; s++) begin
        valid_d[s] = valid_q[s-1];
        data_d[s]  = data_q[s-1];
      end
    end
  end

  always_comb begin
    mode_d      = mode_q;
    sat_d       = sat_q;
    rd_data_d   = rd_data_q;
    rsp_valid_d = rsp_valid_q && !bus.csr_rsp_ready_i;
    if (csr_fire && bus.csr_wr_en_i) begin
      if (addr_mode) mode_d = mode_e'(bus.csr_wr_data_i[2:0]);
      if (addr_sat)  sat_d  = bus.csr_wr_data_i[0];
    end
    if (csr_fire && !bus.csr_wr_en_i) begin
      rsp_valid_d = 1'b1;
      rd_data_d   = '0;
      if (addr_mode)  rd_data_d = RegDataWidth'(mode_q);
      if (addr_sat)   rd_data_d = RegDataWidth'(sat_q);
      if (addr_count) rd_data_d = RegDataWidth'(count_q);
    end
    // CLEAR beats a coincident result handshake.
    count_d = clear_hit ? 32'd0 : count_q + 32'(out_fire);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q     <= '0;
      for (int s = 0; s < PipeDepth; s++) data_q[s] <= '0;
      mode_q      <= ModeAdd;
      sat_q       <= 1'b0;
      count_q     <= '0;
      rd_data_q   <= '0;
      rsp_valid_q <= 1'b0;
    end else begin
      valid_q     <= valid_d;
      for (int s = 0; s < PipeDepth; s++) data_q[s] <= data_d[s];
      mode_q      <= mode_d;
      sat_q       <= sat_d;
      count_q     <= count_d;
      rd_data_q   <= rd_data_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

endmodule

// File: tb/tb_simple_alu_pipe.sv
// Directed bench for simple_alu_pipe built as 2 lanes x 8 bits, PipeDepth 2.
// Expected values are hand-computed; lane 1 occupies the upper byte of each 16-bit vector.
module tb_simple_alu_pipe;
  localparam int Lanes = 2;
  localparam int Dw    = 8;
  localparam int Depth = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic busy;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  simple_alu_pipe_if #(.SpatPar(Lanes), .DataWidth(Dw), .RegDataWidth(32), .RegAddrWidth(3)) bus ();

  simple_alu_pipe #(
    .SpatPar(Lanes), .DataWidth(Dw), .PipeDepth(Depth), .RegCount(8), .RegDataWidth(32)
  ) dut (
    .clk_i(clk), .rst_i(rst), .bus(bus), .busy_o(busy)
  );

  typedef struct {
    logic [2:0]  mode;
    logic        sat;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs [11] = '{
    '{3'd0, 1'b0, 16'h127F, 16'h3401, 16'h4680},
    '{3'd1, 1'b0, 16'h8005, 16'h0107, 16'h7FFE},
    '{3'd2, 1'b0, 16'h0310, 16'h0511, 16'h0F10},
    '{3'd3, 1'b0, 16'hAAF0, 16'h553C, 16'hFFCC},
    '{3'd4, 1'b0, 16'hAAF0, 16'h0F3C, 16'h0A30},
    '{3'd5, 1'b0, 16'h01F0, 16'h800C, 16'h81FC},
    '{3'd6, 1'b0, 16'h7F80, 16'hFF01, 16'h7F01},
    '{3'd7, 1'b0, 16'hFE80, 16'h0201, 16'hFE80},
    '{3'd1, 1'b1, 16'h0580, 16'h0701, 16'hFE80},
    '{3'd0, 1'b1, 16'h807F, 16'hFF01, 16'h807F},
    '{3'd2, 1'b1, 16'h4010, 16'h0411, 16'h0010}
  };

  task automatic check_output(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic timeout_fail(input string tag);
    checks++;
    errors++;
    $error("[TB] FAIL %s: wait bound expired", tag);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic csr_write(input logic [2:0] addr, input logic [31:0] data);
    int n = 0;
    bus.csr_addr_i = addr; bus.csr_wr_data_i = data;
    bus.csr_wr_en_i = 1'b1; bus.csr_req_valid_i = 1'b1;
    #1;
    while (!bus.csr_req_ready_o && n < 50) begin tick(); n++; end
    if (n >= 50) timeout_fail("csr_write_accept");
    tick();
    bus.csr_req_valid_i = 1'b0; bus.csr_wr_en_i = 1'b0;
  endtask

  task automatic csr_read(input logic [2:0] addr, output logic [31:0] data);
    int n = 0;
    bus.csr_addr_i = addr; bus.csr_wr_en_i = 1'b0; bus.csr_req_valid_i = 1'b1;
    #1;
    while (!bus.csr_req_ready_o && n < 50) begin tick(); n++; end
    if (n >= 50) timeout_fail("csr_read_accept");
    tick();
    bus.csr_req_valid_i = 1'b0;
    check_output("csr_rsp_valid", bus.csr_rsp_valid_o, 1'b1);
    data = bus.csr_rd_data_o;
    bus.csr_rsp_ready_i = 1'b1;
    tick();
    bus.csr_rsp_ready_i = 1'b0;
  endtask

  task automatic apply_stimulus(input logic [15:0] a, input logic [15:0] b,
                                output logic [15:0] res, output int lat);
    int n = 0;
    bus.a_i = a; bus.b_i = b; bus.a_valid_i = 1'b1; bus.b_valid_i = 1'b1;
    #1;
    while (!(bus.a_ready_o && bus.b_ready_o) && n < 50) begin tick(); n++; end
    if (n >= 50) timeout_fail("beat_accept");
    tick();
    bus.a_valid_i = 1'b0; bus.b_valid_i = 1'b0;
    lat = 1;
    while (!bus.result_valid_o && lat < 50) begin tick(); lat++; end
    res = bus.result_o;
    tick();
  endtask

  initial begin
    logic [15:0] res;
    logic [15:0] held;
    logic [31:0] rd;
    int          lat;
    int          sent, recv, cyc;
    logic        stalled, fire_in;

    bus.a_i = '0; bus.b_i = '0; bus.a_valid_i = 1'b1; bus.b_valid_i = 1'b1;
    bus.result_ready_i = 1'b1;
    bus.csr_addr_i = '0; bus.csr_wr_data_i = '0; bus.csr_wr_en_i = 1'b0;
    bus.csr_req_valid_i = 1'b0; bus.csr_rsp_ready_i = 1'b0;

    repeat (2) tick();
    check_output("rst_a_ready", bus.a_ready_o, 1'b0);
    check_output("rst_b_ready", bus.b_ready_o, 1'b0);
    check_output("rst_csr_ready", bus.csr_req_ready_o, 1'b0);
    check_output("rst_result_valid", bus.result_valid_o, 1'b0);
    check_output("rst_busy", busy, 1'b0);
    check_output("rst_result", bus.result_o, 16'h0000);
    rst = 1'b0; bus.a_valid_i = 1'b0; bus.b_valid_i = 1'b0;
    tick();

    bus.a_valid_i = 1'b1;
    #1;
    check_output("a_ready_needs_b", bus.a_ready_o, 1'b0);
    check_output("b_ready_from_a", bus.b_ready_o, 1'b1);
    bus.a_valid_i = 1'b0;
    csr_read(3'd0, rd); check_output("rst_mode", rd, 32'd0);
    csr_read(3'd1, rd); check_output("rst_sat", rd, 32'd0);
    csr_read(3'd2, rd); check_output("rst_count", rd, 32'd0);

    // Exact two-cycle latency of a plain add.
    bus.a_i = 16'h1005; bus.b_i = 16'h2007; bus.a_valid_i = 1'b1; bus.b_valid_i = 1'b1;
    tick();
    bus.a_valid_i = 1'b0; bus.b_valid_i = 1'b0;
    check_output("add_t1_valid", bus.result_valid_o, 1'b0);
    check_output("add_t1_busy", busy, 1'b1);
    tick();
    check_output("add_t2_valid", bus.result_valid_o, 1'b1);
    check_output("add_t2_result", bus.result_o, 16'h300C);
    tick();
    check_output("add_t3_valid", bus.result_valid_o, 1'b0);

    for (int i = 0; i < 11; i++) begin
      csr_write(3'd0, 32'(vecs[i].mode));
      csr_write(3'd1, 32'(vecs[i].sat));
      apply_stimulus(vecs[i].a, vecs[i].b, res, lat);
      check_output($sformatf("mode%0d_sat%0d", vecs[i].mode, vecs[i].sat), res, vecs[i].exp);
      check_output("latency", lat, Depth);
    end

    csr_write(3'd0, 32'hFF); csr_read(3'd0, rd); check_output("mode_field", rd, 32'd7);
    csr_write(3'd1, 32'hFE); csr_read(3'd1, rd); check_output("sat_field", rd, 32'd0);
    csr_write(3'd5, 32'h55); csr_read(3'd5, rd); check_output("unmapped_read", rd, 32'd0);
    csr_read(3'd3, rd); check_output("clear_reads_zero", rd, 32'd0);
    csr_write(3'd0, 32'd0);
    csr_read(3'd2, rd); check_output("count_after_12", rd, 32'd12);
    csr_write(3'd3, 32'd1);
    csr_read(3'd2, rd); check_output("count_cleared", rd, 32'd0);

    // Ten back-to-back beats with result_ready toggling every cycle.
    sent = 0; recv = 0; cyc = 0; stalled = 1'b0; held = '0;
    bus.result_ready_i = 1'b0;
    while (recv < 10 && cyc < 200) begin
      if (sent < 10) begin
        bus.a_i = {sent[7:0], sent[7:0]}; bus.b_i = {sent[7:0], 8'd100};
        bus.a_valid_i = 1'b1; bus.b_valid_i = 1'b1;
      end else begin
        bus.a_valid_i = 1'b0; bus.b_valid_i = 1'b0;
      end
      #1;
      if (stalled) begin
        check_output("bp_hold_valid", bus.result_valid_o, 1'b1);
        check_output("bp_hold_data", bus.result_o, held);
      end
      fire_in = bus.a_valid_i && bus.a_ready_o && bus.b_ready_o;
      if (bus.result_valid_o && bus.result_ready_i) begin
        check_output("bp_result", bus.result_o, {8'(2 * recv), 8'(recv + 100)});
        recv++;
      end
      stalled = bus.result_valid_o && !bus.result_ready_i;
      held = bus.result_o;
      tick();
      cyc++;
      if (fire_in) sent++;
      bus.result_ready_i = ~bus.result_ready_i;
    end
    if (recv < 10) timeout_fail("bp_drain");
    bus.a_valid_i = 1'b0; bus.b_valid_i = 1'b0; bus.result_ready_i = 1'b1;
    tick();
    csr_read(3'd2, rd); check_output("bp_count", rd, 32'd10);

    // MODE write issued while a beat is in flight must wait for an empty pipeline.
    bus.a_i = 16'h0203; bus.b_i = 16'h0504; bus.a_valid_i = 1'b1; bus.b_valid_i = 1'b1;
    tick();
    bus.a_valid_i = 1'b0; bus.b_valid_i = 1'b0;
    bus.csr_addr_i = 3'd0; bus.csr_wr_data_i = 32'd2; bus.csr_wr_en_i = 1'b1; bus.csr_req_valid_i = 1'b1;
    #1;
    check_output("cfg_stall_t1", bus.csr_req_ready_o, 1'b0);
    check_output("cfg_stall_busy", busy, 1'b1);
    tick();
    check_output("cfg_stall_t2", bus.csr_req_ready_o, 1'b0);
    check_output("inflight_add_valid", bus.result_valid_o, 1'b1);
    check_output("inflight_add", bus.result_o, 16'h0707);
    tick();
    check_output("cfg_idle_busy", busy, 1'b0);
    check_output("cfg_ready_when_idle", bus.csr_req_ready_o, 1'b1);
    tick();
    bus.csr_req_valid_i = 1'b0; bus.csr_wr_en_i = 1'b0;
    apply_stimulus(16'h0203, 16'h0504, res, lat);
    check_output("next_beat_mul", res, 16'h0A0C);

    bus.a_valid_i = 1'b1; bus.b_valid_i = 1'b1;
    tick();
    bus.a_valid_i = 1'b0; bus.b_valid_i = 1'b0;
    bus.csr_addr_i = 3'd0; bus.csr_req_valid_i = 1'b1;
    #1;
    check_output("read_no_stall", bus.csr_req_ready_o, 1'b1);
    tick();
    bus.csr_req_valid_i = 1'b0;
    check_output("rd_rsp_valid", bus.csr_rsp_valid_o, 1'b1);
    check_output("rd_mode_two", bus.csr_rd_data_o, 32'd2);
    tick();
    check_output("rsp_held_valid", bus.csr_rsp_valid_o, 1'b1);
    check_output("rsp_held_data", bus.csr_rd_data_o, 32'd2);
    check_output("rsp_pending_blocks", bus.csr_req_ready_o, 1'b0);
    bus.csr_rsp_ready_i = 1'b1;
    tick();
    bus.csr_rsp_ready_i = 1'b0;
    check_output("rsp_released", bus.csr_rsp_valid_o, 1'b0);
    tick();
    csr_write(3'd0, 32'd0);

    // Counter wrap from all-ones.
    force dut.count_q = 32'hFFFF_FFFF;
    #1;
    release dut.count_q;
    csr_read(3'd2, rd); check_output("count_preload", rd, 32'hFFFF_FFFF);
    apply_stimulus(16'h0101, 16'h0101, res, lat);
    csr_read(3'd2, rd); check_output("count_wrap", rd, 32'd0);
    apply_stimulus(16'h0101, 16'h0101, res, lat);
    csr_read(3'd2, rd); check_output("count_one", rd, 32'd1);

    bus.a_valid_i = 1'b1; bus.b_valid_i = 1'b1;
    tick();
    bus.a_valid_i = 1'b0; bus.b_valid_i = 1'b0;
    tick();
    bus.csr_addr_i = 3'd3; bus.csr_wr_data_i = 32'd1; bus.csr_wr_en_i = 1'b1; bus.csr_req_valid_i = 1'b1;
    #1;
    check_output("clear_no_stall", bus.csr_req_ready_o, 1'b1);
    check_output("clear_with_handshake", bus.result_valid_o, 1'b1);
    tick();
    bus.csr_req_valid_i = 1'b0; bus.csr_wr_en_i = 1'b0;
    csr_read(3'd2, rd); check_output("count_clear_coincident", rd, 32'd0);

    // Reset with two beats in flight.
    csr_write(3'd0, 32'd3);
    csr_write(3'd1, 32'd1);
    apply_stimulus(16'h1111, 16'h2222, res, lat);
    bus.a_i = 16'h0102; bus.b_i = 16'h0304; bus.a_valid_i = 1'b1; bus.b_valid_i = 1'b1;
    tick();
    bus.a_i = 16'h0506;
    tick();
    rst = 1'b1;
    #1;
    check_output("rst_busy_before", busy, 1'b1);
    check_output("rst_inflight_a_ready", bus.a_ready_o, 1'b0);
    check_output("rst_inflight_csr_ready", bus.csr_req_ready_o, 1'b0);
    tick();
    check_output("rst_flush_valid", bus.result_valid_o, 1'b0);
    check_output("rst_flush_busy", busy, 1'b0);
    check_output("rst_flush_result", bus.result_o, 16'h0000);
    rst = 1'b0; bus.a_valid_i = 1'b0; bus.b_valid_i = 1'b0;
    tick();
    tick();
    check_output("rst_no_ghost", bus.result_valid_o, 1'b0);
    csr_read(3'd2, rd); check_output("rst_count_zero", rd, 32'd0);
    csr_read(3'd0, rd); check_output("rst_mode_zero", rd, 32'd0);
    csr_read(3'd1, rd); check_output("rst_sat_zero", rd, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
